// File: rtl/pov_spi_loader_pkg.sv
// Shared fixed-point parameters and reset view constants for the POV display view path.
package pov_spi_loader_pkg;

  localparam int QM_DEF  = 12;
  localparam int QN_DEF  = 12;
  localparam int NUM_VEC = 6;

  // Start view in units of one half: playerX, playerY, facingX, facingY, vplaneX, vplaneY.
  function automatic int start_halves(input int idx);
    case (idx)
      0:       return 3;
      1:       return 3;
      2:       return 0;
      3:       return 2;
      4:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic longint half_to_fixed(input int halves, input int qn);
    return longint'(halves) * (longint'(1) <<< (qn - 1));
  endfunction

endpackage

// File: rtl/pov_spi_loader_spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronizes the host pins, shifts bits MSB first and
// qualifies each transfer by its exact bit count when ss_n rises.
module spi_frame_rx #(
  parameter int FRAME_W = 144
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               ss_n,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_ok_o,
  output logic               frame_bad_o
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic [2:0]         sclk_q, mosi_q, ss_q;
  logic [1:0]         prime_q, prime_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               sclk_rise, ss_fall, ss_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q  <= 3'b000;
      mosi_q  <= 3'b000;
      ss_q    <= 3'b111;
      prime_q <= 2'd0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      mosi_q  <= {mosi_q[1:0], mosi};
      ss_q    <= {ss_q[1:0], ss_n};
      prime_q <= prime_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    ss_fall   = ~ss_q[1] & ss_q[2];
    ss_rise   = ss_q[1] & ~ss_q[2];
    prime_d   = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    // A transfer cut by reset leaves ss_n low; stay deaf until ss_n is seen idle,
    // otherwise the reset value of the synchronizer would fake a falling edge.
    armed_d   = armed_q | ((prime_q == 2'd2) & ss_q[1]);
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    if (armed_q) begin
      if (ss_fall) begin
        cnt_d = '0;
      end else if (sclk_rise && !ss_q[1]) begin
        shift_d = {shift_q[FRAME_W-2:0], mosi_q[1]};
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
      end
    end
    frame_ok_o  = armed_q & ss_rise & (cnt_q == CNT_FULL);
    frame_bad_o = armed_q & ss_rise & (cnt_q != CNT_FULL);
  end

  assign frame_o = shift_q;

endmodule

// File: rtl/pov_spi_loader.sv
// View-vector loader: frames arrive over SPI into a shadow buffer and are committed
// to the output registers on the next vsync rising edge.
module pov_spi_loader
  import pov_spi_loader_pkg::*;
#(
  parameter int QM = QM_DEF,
  parameter int QN = QN_DEF,
  localparam int W = QM + QN
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         vsync,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         ss_n,
  output logic [W-1:0] playerX,
  output logic [W-1:0] playerY,
  output logic [W-1:0] facingX,
  output logic [W-1:0] facingY,
  output logic [W-1:0] vplaneX,
  output logic [W-1:0] vplaneY,
  output logic         pending,
  output logic         committed,
  output logic         frame_err
);

  localparam int FRAME_W = NUM_VEC * W;

  logic [FRAME_W-1:0] frame_bits;
  logic               frame_ok, frame_bad;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [2:0]         vsync_q;
  logic               pending_q, pending_d;
  logic               committed_q, frame_err_q;
  logic               commit;
  logic [W-1:0]       view_q [NUM_VEC];

  spi_frame_rx #(.FRAME_W(FRAME_W)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .ss_n       (ss_n),
    .frame_o    (frame_bits),
    .frame_ok_o (frame_ok),
    .frame_bad_o(frame_bad)
  );

  // Commit looks only at the registered pending/shadow, so a frame landing in the
  // same clk as the vsync edge waits for the following edge.
  always_comb begin
    commit    = vsync_q[1] & ~vsync_q[2] & pending_q;
    shadow_d  = frame_ok ? frame_bits : shadow_q;
    pending_d = pending_q;
    if (commit)   pending_d = 1'b0;
    if (frame_ok) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 3'b000;
      pending_q   <= 1'b0;
      committed_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vsync_q     <= {vsync_q[1:0], vsync};
      pending_q   <= pending_d;
      committed_q <= commit;
      frame_err_q <= frame_bad;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  generate
    for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_view
      localparam logic [W-1:0] RST_VAL = W'(half_to_fixed(start_halves(gi), QN));
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    view_q[gi] <= RST_VAL;
        else if (commit) view_q[gi] <= shadow_q[(NUM_VEC-gi)*W-1 -: W];
      end
    end
  endgenerate

  assign playerX   = view_q[0];
  assign playerY   = view_q[1];
  assign facingX   = view_q[2];
  assign facingY   = view_q[3];
  assign vplaneX   = view_q[4];
  assign vplaneY   = view_q[5];
  assign pending   = pending_q;
  assign committed = committed_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pov_spi_loader.sv
// Directed bench for pov_spi_loader: reset, commit, short frame, overwrite, collision, reset mid-transfer.
module tb_pov_spi_loader;

  localparam int W  = 24;
  localparam int FW = 6 * W;

  logic clk = 1'b0;
  logic reset_n, vsync, sclk, mosi, ss_n;
  logic [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic pending, committed, frame_err;

  int checks = 0;
  int failures = 0;
  int commit_cnt = 0;
  int err_cnt = 0;

  localparam logic [FW-1:0] RST_VIEW = {24'h001800, 24'h001800, 24'h000000,
                                        24'h001000, 24'hFFF800, 24'h000000};
  localparam logic [FW-1:0] F1 = {24'h002800, 24'h003000, 24'h001000,
                                  24'h000000, 24'h000000, 24'h000800};
  localparam logic [FW-1:0] FA = {24'h111111, 24'h222222, 24'h333333,
                                  24'h444444, 24'h555555, 24'h666666};
  localparam logic [FW-1:0] FB = {24'hA00001, 24'hB00002, 24'hC00003,
                                  24'hD00004, 24'hE00005, 24'hF00006};
  localparam logic [FW-1:0] FC = {24'h000123, 24'hFFFEDC, 24'h000800,
                                  24'hFFF000, 24'h001000, 24'h7FFFFF};
  localparam logic [FW-1:0] FE = {24'h004000, 24'h005800, 24'hFFF000,
                                  24'h000000, 24'h000000, 24'hFFF800};

  pov_spi_loader #(.QM(12), .QN(12)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .vsync    (vsync),
    .sclk     (sclk),
    .mosi     (mosi),
    .ss_n     (ss_n),
    .playerX  (playerX),
    .playerY  (playerY),
    .facingX  (facingX),
    .facingY  (facingY),
    .vplaneX  (vplaneX),
    .vplaneY  (vplaneY),
    .pending  (pending),
    .committed(committed),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (committed) commit_cnt++;
    if (frame_err) err_cnt++;
  end

  function automatic logic [FW-1:0] view();
    return {playerX, playerY, facingX, facingY, vplaneX, vplaneY};
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [FW-1:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[FW-1-i];
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] data, input int nbits);
    ss_n = 1'b0;
    clks(4);
    spi_bits(data, nbits);
    clks(4);
    ss_n = 1'b1;
    clks(8);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    clks(8);
    vsync = 1'b0;
    clks(8);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vsync = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    clks(4);
    reset_n = 1'b1;
    clks(4);
    checks++; if (playerX !== 24'h001800) begin failures++; $display("FAIL reset_playerX actual=%h required=%h", playerX, 24'h001800); end
    checks++; if (playerY !== 24'h001800) begin failures++; $display("FAIL reset_playerY actual=%h required=%h", playerY, 24'h001800); end
    checks++; if (facingX !== 24'h000000) begin failures++; $display("FAIL reset_facingX actual=%h required=%h", facingX, 24'h000000); end
    checks++; if (facingY !== 24'h001000) begin failures++; $display("FAIL reset_facingY actual=%h required=%h", facingY, 24'h001000); end
    checks++; if (vplaneX !== 24'hFFF800) begin failures++; $display("FAIL reset_vplaneX actual=%h required=%h", vplaneX, 24'hFFF800); end
    checks++; if (vplaneY !== 24'h000000) begin failures++; $display("FAIL reset_vplaneY actual=%h required=%h", vplaneY, 24'h000000); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending actual=%b required=0", pending); end
    $display("reset: view=%h pending=%b", view(), pending);
  endtask

  task automatic test_valid_frame();
    int c0;
    send_frame(F1, FW);
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL valid_pending actual=%b required=1", pending); end
    checks++; if (view() !== RST_VIEW) begin failures++; $display("FAIL valid_precommit actual=%h required=%h", view(), RST_VIEW); end
    c0 = commit_cnt;
    vsync_pulse();
    checks++; if (view() !== F1) begin failures++; $display("FAIL valid_commit actual=%h required=%h", view(), F1); end
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL valid_pulses actual=%0d required=1", commit_cnt - c0); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL valid_pending_clr actual=%b required=0", pending); end
    $display("valid frame: view=%h pulses=%0d", view(), commit_cnt - c0);
  endtask

  task automatic test_short_frame();
    int e0, c0;
    e0 = err_cnt;
    send_frame(FA, FW - 1);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL short_err actual=%0d required=1", err_cnt - e0); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL short_pending actual=%b required=0", pending); end
    c0 = commit_cnt;
    vsync_pulse();
    checks++; if (view() !== F1) begin failures++; $display("FAIL short_view actual=%h required=%h", view(), F1); end
    checks++; if (commit_cnt - c0 !== 0) begin failures++; $display("FAIL short_pulses actual=%0d required=0", commit_cnt - c0); end
    $display("short frame: errs=%0d view=%h", err_cnt - e0, view());
  endtask

  task automatic test_overwrite();
    int c0;
    send_frame(FA, FW);
    send_frame(FB, FW);
    c0 = commit_cnt;
    vsync_pulse();
    checks++; if (view() !== FB) begin failures++; $display("FAIL overwrite_view actual=%h required=%h", view(), FB); end
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL overwrite_pulses actual=%0d required=1", commit_cnt - c0); end
    $display("overwrite: view=%h pulses=%0d", view(), commit_cnt - c0);
  endtask

  task automatic test_collision();
    int c0;
    ss_n = 1'b0;
    clks(4);
    spi_bits(FC, FW);
    clks(4);
    c0 = commit_cnt;
    ss_n  = 1'b1;
    vsync = 1'b1;
    clks(8);
    vsync = 1'b0;
    clks(8);
    checks++; if (commit_cnt - c0 !== 0) begin failures++; $display("FAIL collision_nocommit actual=%0d required=0", commit_cnt - c0); end
    checks++; if (view() !== FB) begin failures++; $display("FAIL collision_hold actual=%h required=%h", view(), FB); end
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL collision_pending actual=%b required=1", pending); end
    vsync_pulse();
    checks++; if (view() !== FC) begin failures++; $display("FAIL collision_next actual=%h required=%h", view(), FC); end
    checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL collision_pulses actual=%0d required=1", commit_cnt - c0); end
    $display("collision: view=%h pulses=%0d", view(), commit_cnt - c0);
  endtask

  task automatic test_reset_mid();
    int e0;
    ss_n = 1'b0;
    clks(4);
    spi_bits(FA, 70);
    reset_n = 1'b0;
    clks(3);
    checks++; if (view() !== RST_VIEW) begin failures++; $display("FAIL midreset_view actual=%h required=%h", view(), RST_VIEW); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL midreset_pending actual=%b required=0", pending); end
    reset_n = 1'b1;
    clks(2);
    e0 = err_cnt;
    spi_bits(FA, 10);
    clks(4);
    ss_n = 1'b1;
    clks(8);
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL midreset_remnant actual=%b required=0", pending); end
    checks++; if (view() !== RST_VIEW) begin failures++; $display("FAIL midreset_hold actual=%h required=%h", view(), RST_VIEW); end
    send_frame(FE, FW);
    vsync_pulse();
    checks++; if (view() !== FE) begin failures++; $display("FAIL midreset_commit actual=%h required=%h", view(), FE); end
    $display("reset mid-transfer: view=%h remnant_errs=%0d", view(), err_cnt - e0);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_short_frame();
    test_overwrite();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
